// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: sequential word fetch over a req/ack port,
// small PC-tagged FIFO feeding IF/ID, flush-and-restart on redirect.
module inst_prefetch_buffer #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  input  logic                         stall_i,
  output logic                         mem_req_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic                         mem_ack_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic                         inst_valid_o,
  output logic [DATA_W-1:0]            inst_o,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_MASK  = ~ADDR_W'(3);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];

  logic              xfer;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [CNT_W-1:0]  count_after;
  entry_t            head;

  assign xfer        = req_q & mem_ack_i;
  assign not_empty   = (count_q != '0);
  assign pop         = not_empty & ~stall_i & ~redirect_i;
  assign redir_pc    = redirect_pc_i & PC_MASK;
  assign next_pc     = fetch_pc_q + PC_STEP;
  // Occupancy once the word being accepted now lands and any pop retires.
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

  // Fetch control: request issue, address sequencing and redirect draining.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
        end else if (count_q < FULL_CNT) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
          if (xfer) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (xfer) begin
          push       = 1'b1;
          fetch_pc_d = next_pc;
          if (count_after < FULL_CNT) begin
            addr_d = next_pc;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        // Stale request must complete; its data is thrown away.
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
        end
        if (xfer) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy and storage; redirect wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fifo_d   = fifo_q;

    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = '{pc: fetch_pc_q, data: mem_rdata_i};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

  // Head presentation is combinational and reads zero when empty.
  always_comb begin
    head = fifo_q[rd_ptr_q];
    if (!not_empty) begin
      head = '0;
    end
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign inst_valid_o = not_empty;
  assign inst_o       = head.data;
  assign pc_o         = head.pc;
  assign count_o      = count_q;

endmodule
